// File: rtl/seq_divider.sv
// seq_divider: sequential restoring shift-subtract divider.
//   Produces one quotient bit per clock. A request is accepted in IDLE on
//   start; quotient/remainder/div_by_zero are registered in FIN, which also
//   raises a one-cycle done pulse. Results are held until the next FIN.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request, sampled only in IDLE (not in the done cycle)
//   dividend, divisor  WIDTH-bit operands, captured on accepted start
//   busy               high while the shift-subtract loop runs
//   done               one-cycle pulse, results valid from this cycle on
//   quotient/remainder WIDTH-bit results
//   div_by_zero        set with done when the captured divisor was zero
//
// Optional feature: define SEQ_DIV_SIGNED_EN for two's-complement operands
// (magnitudes run through the same loop, signs are fixed up in FIN).
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder (always < divisor)
    logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifting out, quotient in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmdr_q, rmdr_d;
    logic             dbz_q, dbz_d;

    // One extra bit on the shifted remainder keeps the compare exact.
    logic [WIDTH:0]   shifted;
    logic             accept;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix, a_fix;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    // The done cycle is already IDLE; a start there must not be taken.
    assign accept  = (state_q == IDLE) && start && !done_q;

`ifdef SEQ_DIV_SIGNED_EN
    logic qneg_q, qneg_d, rneg_q, rneg_d;

    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign q_fix = qneg_q ? -quo_q : quo_q;
    assign r_fix = rneg_q ? -rem_q : rem_q;
    // On divide-by-zero quo_q still holds |dividend|; re-signing restores it.
    assign a_fix = rneg_q ? -quo_q : quo_q;

    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (accept) begin
            qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d = dividend[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fix = quo_q;
    assign r_fix = rem_q;
    assign a_fix = quo_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rmdr_d  = rmdr_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    quo_d  = a_mag;
                    dvs_d  = b_mag;
                    rem_d  = '0;
                    zero_d = (divisor == '0);
                    if (divisor == '0) begin
                        cnt_d   = '0;
                        state_d = FIN;
                    end else begin
                        cnt_d   = CW'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (shifted >= {1'b0, dvs_q}) begin
                    // True difference is < divisor, so WIDTH bits hold it.
                    rem_d = shifted[WIDTH-1:0] - dvs_q;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                dbz_d   = zero_q;
                if (zero_q) begin
                    quot_d = '1;
                    rmdr_d = a_fix;
                end else begin
                    quot_d = q_fix;
                    rmdr_d = r_fix;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CALC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rmdr_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rmdr_q  <= rmdr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rmdr_q;
    assign div_by_zero = dbz_q;

endmodule
